peg_psum_accum: RTL

PEG_PSUM_ACCUM -- requirements
Module: peg_psum_accum

---
 rtl/peg_psum_accum.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/peg_psum_accum.sv
// rtl/peg_psum_accum.sv - tiled partial-sum accumulator: saturating per-row sums, then drained in row order with clear-on-read
module peg_psum_accum #(
  parameter int DEPTH  = 64,
  parameter int ROW_W  = 6,
  parameter int PROD_W = 30,
  parameter int ACC_W  = 40
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROW_W-1:0]  in_row,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic [ACC_W-1:0]  out_data
);

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q [DEPTH];

  logic               s1_vld_q, s1_vld_d;
  logic [ROW_W-1:0]   s1_row_q, s1_row_d;
  logic [ACC_W-1:0]   s1_prod_q, s1_prod_d;
  logic [ACC_W-1:0]   s1_base_q, s1_base_d;
  logic               s2_vld_q, s2_vld_d;
  logic [ROW_W-1:0]   s2_row_q, s2_row_d;
  logic [ACC_W-1:0]   s2_sum_q, s2_sum_d;

  logic [ACC_W:0]     s1_wide;
  logic [ACC_W-1:0]   s1_sum;
  logic               accept, drain_hs;
  logic               acc_we;
  logic [ROW_W-1:0]   acc_waddr;
  logic [ACC_W-1:0]   acc_wdata;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign accept    = in_valid & in_ready;
  assign drain_hs  = out_valid & out_ready;
  assign out_row   = idx_q;
  assign out_data  = acc_q[idx_q];

  // One extra bit of headroom exposes signed overflow for clamping.
  always_comb begin
    s1_wide = {s1_base_q[ACC_W-1], s1_base_q} + {s1_prod_q[ACC_W-1], s1_prod_q};
    if (s1_wide[ACC_W] != s1_wide[ACC_W-1]) begin
      s1_sum = s1_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      s1_sum = s1_wide[ACC_W-1:0];
    end
  end

  // Newest in-flight beat wins: S1's pending sum, then S2's unwritten sum, then storage.
  always_comb begin
    s1_vld_d  = accept;
    s1_row_d  = in_row;
    s1_prod_d = ACC_W'($signed(in_prod));
    if (s1_vld_q && (s1_row_q == in_row)) begin
      s1_base_d = s1_sum;
    end else if (s2_vld_q && (s2_row_q == in_row)) begin
      s1_base_d = s2_sum_q;
    end else begin
      s1_base_d = acc_q[in_row];
    end
    s2_vld_d = s1_vld_q;
    s2_row_d = s1_row_q;
    s2_sum_d = s1_sum;
  end

  // Drain only runs with an empty pipeline, so the two write sources never collide.
  always_comb begin
    acc_we    = 1'b0;
    acc_waddr = s2_row_q;
    acc_wdata = s2_sum_q;
    if (s2_vld_q) begin
      acc_we = 1'b1;
    end else if (drain_hs) begin
      acc_we    = 1'b1;
      acc_waddr = idx_q;
      acc_wdata = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ACCUM: begin
        if (accept && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (!s1_vld_q && !s2_vld_q) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          if (idx_q == ROW_W'(DEPTH - 1)) begin
            state_d = ACCUM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ROW_W'(1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ACCUM;
      idx_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_row_q  <= '0;
      s1_prod_q <= '0;
      s1_base_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_row_q  <= '0;
      s2_sum_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s1_vld_q  <= s1_vld_d;
      s1_row_q  <= s1_row_d;
      s1_prod_q <= s1_prod_d;
      s1_base_q <= s1_base_d;
      s2_vld_q  <= s2_vld_d;
      s2_row_q  <= s2_row_d;
      s2_sum_q  <= s2_sum_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
    end else if (acc_we) begin
      acc_q[acc_waddr] <= acc_wdata;
    end
  end

endmodule
